// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler sharing one FPU (add/mul/div) among N_REQ requesters.
// Latency: add/mul rsp_valid LAT+1 edges after the request handshake, div one edge after div_ready, illegal op one edge.
// Backpressure: one op in flight; requests wait in IDLE, and RESP holds until the owner's rsp_ready.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   req_valid/req_ready          per-requester request handshake (req_ready combinational, one-hot)
//   req_op/req_a/req_b           packed per-requester opcode and operands (slice i)
//   rsp_valid/rsp_ready          per-requester response handshake (rsp_valid one-hot to owner)
//   rsp_data/rsp_status          shared response bus: 00 ok, 01 div by zero, 10 div timeout, 11 illegal op
//   busy                         registered, high whenever not IDLE
//   fpu_op1/fpu_op2/fpu_clk_en   operands and per-unit clock enables (0 add, 1 mul, 2 div)
//   add/mul/div_result, div_ready, div_by_zero   unit outputs
module fpu_op_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ADD_LAT     = 2,
    parameter int MUL_LAT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [1:0]           rsp_status,
    output logic                 busy,
    output logic [31:0]          fpu_op1,
    output logic [31:0]          fpu_op2,
    output logic [2:0]           fpu_clk_en,
    input  logic [31:0]          add_result,
    input  logic [31:0]          mul_result,
    input  logic [31:0]          div_result,
    input  logic                 div_ready,
    input  logic                 div_by_zero
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [7:0] ADD_LAST = 8'(ADD_LAT - 1);
    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DIVZERO = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         op_q, op_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        op1_d, op2_d;
    logic [31:0]        rsp_data_d;
    logic [1:0]         rsp_status_d;
    logic [2:0]         clk_en_d;

    // Round-robin search: first valid at or after last_grant+1, with wrap.
    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   idx_v;
    int                 idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx   = (int'(last_grant_q) + 1 + k) % N_REQ;
            idx_v = IDX_W'(idx);
            if (!gnt_found && req_valid[idx_v]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_v;
            end
        end
    end

    // Operand/opcode mux for the candidate grant.
    logic [7:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    assign sel_op = req_op[{gnt_idx, 3'b000}  +: 8];
    assign sel_a  = req_a [{gnt_idx, 5'b00000} +: 32];
    assign sel_b  = req_b [{gnt_idx, 5'b00000} +: 32];

    // Ready is suppressed during reset so no handshake is seen on a reset edge.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_found && !ARESET) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        op1_d        = fpu_op1;
        op2_d        = fpu_op2;
        rsp_data_d   = rsp_data;
        rsp_status_d = rsp_status;
        clk_en_d     = 3'b000;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    op_d    = sel_op;
                    op1_d   = sel_a;
                    op2_d   = sel_b;
                    cnt_d   = 8'd0;
                    if (sel_op < 8'd3) begin
                        state_d  = S_EXEC;
                        clk_en_d = 3'b001 << sel_op[1:0];
                    end else begin
                        // Illegal opcode never touches a unit.
                        state_d      = S_RESP;
                        rsp_data_d   = 32'd0;
                        rsp_status_d = ST_ILLEGAL;
                    end
                end
            end

            S_EXEC: begin
                cnt_d    = cnt_q + 8'd1;
                clk_en_d = 3'b001 << op_q[1:0];
                unique case (op_q)
                    8'd0: begin
                        if (cnt_q == ADD_LAST) begin
                            state_d      = S_RESP;
                            rsp_data_d   = add_result;
                            rsp_status_d = ST_OK;
                            clk_en_d     = 3'b000;
                        end
                    end
                    8'd1: begin
                        if (cnt_q == MUL_LAST) begin
                            state_d      = S_RESP;
                            rsp_data_d   = mul_result;
                            rsp_status_d = ST_OK;
                            clk_en_d     = 3'b000;
                        end
                    end
                    8'd2: begin
                        // A completion on the last allowed cycle beats the timeout.
                        if (div_ready) begin
                            state_d      = S_RESP;
                            rsp_data_d   = div_result;
                            rsp_status_d = div_by_zero ? ST_DIVZERO : ST_OK;
                            clk_en_d     = 3'b000;
                        end else if (cnt_q == DIV_LAST) begin
                            state_d      = S_RESP;
                            rsp_data_d   = 32'd0;
                            rsp_status_d = ST_TIMEOUT;
                            clk_en_d     = 3'b000;
                        end
                    end
                    default: begin
                        state_d      = S_RESP;
                        rsp_data_d   = 32'd0;
                        rsp_status_d = ST_ILLEGAL;
                        clk_en_d     = 3'b000;
                    end
                endcase
            end

            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
            op_q         <= 8'd0;
            cnt_q        <= 8'd0;
            fpu_op1      <= 32'd0;
            fpu_op2      <= 32'd0;
            rsp_data     <= 32'd0;
            rsp_status   <= 2'b00;
            fpu_clk_en   <= 3'b000;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            fpu_op1      <= op1_d;
            fpu_op2      <= op2_d;
            rsp_data     <= rsp_data_d;
            rsp_status   <= rsp_status_d;
            fpu_clk_en   <= clk_en_d;
            busy         <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Scoreboard bench for fpu_op_scheduler with behavioural FPU unit models.
// Latency: responses checked against per-op latency from the request handshake.
// Backpressure: exercises held rsp_ready, contention and reset during EXEC.
module tb_fpu_op_scheduler;

    localparam int N         = 4;
    localparam int ADD_LAT   = 2;
    localparam int MUL_LAT   = 1;
    localparam int DIV_TO    = 64;
    localparam int DIV_DELAY = 5;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [8*N-1:0]    req_op = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '1;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_status;
    logic              busy;
    logic [31:0]       fpu_op1, fpu_op2;
    logic [2:0]        fpu_clk_en;
    logic [31:0]       add_result, mul_result, div_result;
    logic              div_ready, div_by_zero;

    fpu_op_scheduler #(
        .N_REQ(N), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy),
        .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_clk_en(fpu_clk_en),
        .add_result(add_result), .mul_result(mul_result), .div_result(div_result),
        .div_ready(div_ready), .div_by_zero(div_by_zero)
    );

    always #5 ACLK = ~ACLK;

    // Unit models: exact IEEE results for the named vectors, distinct integer stand-ins otherwise.
    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40A00000 && b == 32'h41400000) return 32'h41880000;
        return a + b;
    endfunction
    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40A00000 && b == 32'h41400000) return 32'h42700000;
        return a ^ b;
    endfunction
    function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h41400000 && b == 32'h40800000) return 32'h40400000;
        return a - b;
    endfunction

    bit         div_stuck = 1'b0;
    logic [7:0] div_cnt = 8'd0;
    int         cyc = 0;

    assign add_result  = f_add(fpu_op1, fpu_op2);
    assign mul_result  = f_mul(fpu_op1, fpu_op2);
    assign div_result  = (fpu_op2 == 32'd0) ? 32'h7F800000 : f_div(fpu_op1, fpu_op2);
    assign div_ready   = fpu_clk_en[2] && !div_stuck && (div_cnt == 8'(DIV_DELAY - 1));
    assign div_by_zero = div_ready && (fpu_op2 == 32'd0);

    always @(posedge ACLK) begin
        cyc     <= cyc + 1;
        div_cnt <= fpu_clk_en[2] ? div_cnt + 8'd1 : 8'd0;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [1:0]  st;
        int          lat;
        logic [2:0]  en;
        int          en_cyc;
        int          hs_cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   model_last = N - 1;
    int   en_cnt = 0;
    int   en_bad = 0;
    bit   first_rsp = 1'b0;

    function automatic int model_grant(input logic [N-1:0] v, input int last);
        for (int k = 0; k < N; k++) begin
            if (v[(last + 1 + k) % N]) return (last + 1 + k) % N;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(input int g, input logic [7:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input bit stuck, input int c);
        exp_t e;
        e.owner = g; e.hs_cyc = c;
        e.data = 32'd0; e.st = 2'b11; e.lat = 1; e.en = 3'b000; e.en_cyc = 0;
        if (op == 8'd0) begin
            e.data = f_add(a, b); e.st = 2'b00; e.lat = ADD_LAT + 1; e.en = 3'b001; e.en_cyc = ADD_LAT;
        end else if (op == 8'd1) begin
            e.data = f_mul(a, b); e.st = 2'b00; e.lat = MUL_LAT + 1; e.en = 3'b010; e.en_cyc = MUL_LAT;
        end else if (op == 8'd2) begin
            e.en = 3'b100;
            if (stuck) begin
                e.data = 32'd0; e.st = 2'b10; e.lat = DIV_TO + 1; e.en_cyc = DIV_TO;
            end else begin
                e.data = (b == 32'd0) ? 32'h7F800000 : f_div(a, b);
                e.st = (b == 32'd0) ? 2'b01 : 2'b00;
                e.lat = DIV_DELAY + 1; e.en_cyc = DIV_DELAY;
            end
        end
        return e;
    endfunction

    // Monitor: grant prediction, enable accounting, response scoreboard.
    always @(negedge ACLK) begin
        int   g;
        bit   exp_busy;
        exp_t e;
        if (ARESET) begin
            sb.delete();
            model_last = N - 1;
            first_rsp  = 1'b0;
        end else begin
            exp_busy = (sb.size() != 0);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_busy) begin
                chk("rdy_busy", 32'(req_ready), 32'd0);
            end else begin
                g = model_grant(req_valid, model_last);
                chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
                if (g >= 0 && (req_valid & req_ready) != '0) begin
                    e = make_exp(g, req_op[8*g +: 8], req_a[32*g +: 32], req_b[32*g +: 32], div_stuck, cyc);
                    sb.push_back(e);
                    grant_log.push_back(g);
                    grant_cyc.push_back(cyc);
                    en_cnt = 0; en_bad = 0; first_rsp = 1'b1;
                end
            end
            if (fpu_clk_en != 3'b000) begin
                if (!exp_busy) chk("en_idle", 32'(fpu_clk_en), 32'd0);
                else begin
                    en_cnt++;
                    if (fpu_clk_en != sb[0].en) en_bad++;
                end
            end
            if (rsp_valid != '0) begin
                if (!exp_busy) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    if (first_rsp) begin
                        chk("latency", 32'(cyc - sb[0].hs_cyc), 32'(sb[0].lat));
                        chk("en_cycles", 32'(en_cnt), 32'(sb[0].en_cyc));
                        chk("en_wrong_unit", 32'(en_bad), 32'd0);
                        first_rsp = 1'b0;
                    end
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << sb[0].owner);
                    chk("rsp_data", rsp_data, sb[0].data);
                    chk("rsp_status", 32'(rsp_status), 32'(sb[0].st));
                    chk("en_in_resp", 32'(fpu_clk_en), 32'd0);
                    if (rsp_ready[sb[0].owner]) begin
                        model_last = sb[0].owner;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic start_req(input int i, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[8*i +: 8]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_hs(input int i);
        bit got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge ACLK);
            if (req_valid[i] && req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("hs_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        start_req(i, op, a, b);
        wait_hs(i);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge ACLK); #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grants(input int n);
        bit done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge ACLK); #1;
            if (grant_log.size() >= n) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int exp_order[5];
        bit seen;
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_clk_en", 32'(fpu_clk_en), 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_op1", fpu_op1, 32'd0);
        chk("rst_op2", fpu_op2, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        ARESET = 1'b0;

        // Directed ops: add, mul, div, div by zero, div timeout, illegal.
        issue(0, 8'd0, 32'h40A00000, 32'h41400000); drain();
        issue(1, 8'd1, 32'h40A00000, 32'h41400000); drain();
        issue(0, 8'd2, 32'h41400000, 32'h40800000); drain();
        issue(0, 8'd2, 32'h41400000, 32'h00000000); drain();
        div_stuck = 1'b1;
        issue(3, 8'd2, 32'h3F800000, 32'h40000000); drain();
        div_stuck = 1'b0;
        issue(2, 8'h05, 32'h12345678, 32'h9ABCDEF0); drain();
        chk("op1_after_illegal", fpu_op1, 32'h12345678);

        // Round-robin with all requesters saturating; last grant was 3 so order starts at 0.
        issue(3, 8'd0, 32'h00000100, 32'h00000001); drain();
        grant_log.delete(); grant_cyc.delete();
        for (int i = 0; i < N; i++) start_req(i, 8'd0, 32'h1000 * (i + 1), 32'(i + 7));
        wait_grants(5);
        req_valid = '0;
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[k]), 32'(exp_order[k]));
        for (int k = 0; k < 4; k++) chk("rr_spacing", 32'(grant_cyc[k+1] - grant_cyc[k]), 32'(ADD_LAT + 2));
        drain();

        // Response backpressure on requester 0 while requester 1 waits.
        rsp_ready[0] = 1'b0;
        issue(0, 8'd1, 32'h40A00000, 32'h41400000);
        start_req(1, 8'd0, 32'h00000011, 32'h00000022);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge ACLK);
            if (rsp_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("bp_rsp_timeout", 32'd0, 32'd1);
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge ACLK);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_data", rsp_data, 32'h42700000);
        end
        @(posedge ACLK); #1;
        rsp_ready[0] = 1'b1;
        wait_hs(1);
        drain();

        // Reset during a divide; afterwards requester 0 has first priority.
        div_stuck = 1'b1;
        issue(1, 8'd2, 32'h41400000, 32'h40800000);
        repeat (5) @(negedge ACLK);
        chk("pre_rst_clk_en", 32'(fpu_clk_en), 32'b100);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        for (int i = 0; i < N; i++) start_req(i, 8'd0, 32'h200 * (i + 1), 32'(i + 3));
        @(posedge ACLK); #1;
        chk("mid_rst_clk_en", 32'(fpu_clk_en), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_status", 32'(rsp_status), 32'd0);
        chk("mid_rst_op1", fpu_op1, 32'd0);
        chk("mid_rst_op2", fpu_op2, 32'd0);
        grant_log.delete(); grant_cyc.delete();
        ARESET = 1'b0;
        div_stuck = 1'b0;
        wait_grants(1);
        req_valid = '0;
        if (grant_log.size() > 0) chk("post_rst_first_grant", 32'(grant_log[0]), 32'd0);
        drain();

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
